// File: rtl/la_rle_capture_if.sv
// AXI-Stream style trace uplink bundle between the capture engine and its consumer.
`timescale 1ns/1ps
interface la_rle_capture_if #(
    parameter int TW = 32
);
    logic [TW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;

    modport master (output m_tdata, m_tvalid, m_tlast, input m_tready);
    modport slave  (input m_tdata, m_tvalid, m_tlast, output m_tready);
endinterface

// File: rtl/la_rle_capture.sv
// Logic-analyzer capture engine: trigger, run-length encoding of masked channels into
// {repeat_count, value} traces, overflow dropping with null-word resync, FWFT FIFO and AXIS packetising.
//
//   state   | meaning
//   IDLE    | disabled, FIFO may still hold data from a previous run
//   ARMED   | enabled, waiting for trigger (immediate or pattern)
//   CAPTURE | run-length encoding, one trace per value change or counter saturation
//   DRAIN   | push final trace with last-flag, then wait for FIFO empty
`timescale 1ns/1ps
module la_rle_capture #(
    parameter int NUM_CH     = 24,
    parameter int RC_WIDTH   = 8,
    parameter int FIFO_DEPTH = 64,
    localparam int TW = NUM_CH + RC_WIDTH,
    localparam int LW = $clog2(FIFO_DEPTH) + 1,
    localparam int PW = $clog2(FIFO_DEPTH)
) (
    input  logic                axis_clk,
    input  logic                axis_rst,
    input  logic                cfg_enable,
    input  logic [NUM_CH-1:0]   cfg_ch_mask,
    input  logic                cfg_trig_mode,
    input  logic [NUM_CH-1:0]   cfg_trig_mask,
    input  logic [NUM_CH-1:0]   cfg_trig_value,
    input  logic [LW-1:0]       cfg_h_thresh,
    input  logic [LW-1:0]       cfg_l_thresh,
    input  logic [7:0]          cfg_pkt_len,
    input  logic [NUM_CH-1:0]   up_la_data,
    la_rle_capture_if.master    m_axis,
    output logic                la_hpri_req,
    output logic [LW-1:0]       fifo_level,
    output logic [15:0]         drop_count,
    output logic [1:0]          la_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

    localparam logic [LW-1:0]       FULL_LVL = LW'(FIFO_DEPTH);
    localparam logic [RC_WIDTH-1:0] RC_MAX   = {RC_WIDTH{1'b1}};

    state_t              state_q, state_d;
    logic [RC_WIDTH-1:0] rc_q, rc_d;
    logic [NUM_CH-1:0]   r_val_q, r_val_d;
    logic                blocked_q, blocked_d;
    logic                drained_q, drained_d;
    logic [15:0]         drop_q, drop_d;
    logic [7:0]          beat_q, beat_d;
    logic                hpri_q, hpri_d;
    logic [LW-1:0]       level_q, level_d;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;

    logic [TW:0]         mem [FIFO_DEPTH];
    logic [TW:0]         head;
    logic                push, push_last, pop, drop_evt;
    logic [TW-1:0]       push_word, trace;
    logic                trig_hit, chg, emit, level_full, tvalid, tlast;
    logic [7:0]          pkt_eff;

    assign trace      = {rc_q, r_val_q & cfg_ch_mask};
    assign trig_hit   = (up_la_data & cfg_trig_mask) == (cfg_trig_value & cfg_trig_mask);
    assign chg        = |(cfg_ch_mask & (up_la_data ^ r_val_q));
    assign emit       = chg || (rc_q == RC_MAX);
    assign level_full = (level_q == FULL_LVL);
    assign pkt_eff    = (cfg_pkt_len == 8'd0) ? 8'd1 : cfg_pkt_len;
    assign head       = mem[rd_ptr_q];
    assign tvalid     = (level_q != '0);
    assign tlast      = tvalid && ((beat_q == pkt_eff) || head[TW]);
    assign pop        = tvalid && m_axis.m_tready;

    always_comb begin
        state_d   = state_q;
        rc_d      = rc_q;
        r_val_d   = r_val_q;
        blocked_d = blocked_q;
        drained_d = drained_q;
        drop_d    = drop_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_word = '0;
        drop_evt  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_enable) begin
                    state_d = S_ARMED;
                    drop_d  = '0;
                end
            end
            S_ARMED: begin
                if (!cfg_enable) begin
                    state_d = S_IDLE;
                end else if (!cfg_trig_mode || trig_hit) begin
                    state_d = S_CAPTURE;
                    r_val_d = up_la_data;
                    rc_d    = RC_WIDTH'(1);
                end
            end
            S_CAPTURE: begin
                if (!cfg_enable) begin
                    state_d   = S_DRAIN;
                    drained_d = 1'b0;
                end else begin
                    if (emit) begin
                        r_val_d = up_la_data;
                        rc_d    = RC_WIDTH'(1);
                    end else begin
                        rc_d = rc_q + 1'b1;
                    end
                    // The null word marks the gap in the trace stream; a trace in the same cycle is lost.
                    if (blocked_q && (level_q <= cfg_l_thresh)) begin
                        push      = 1'b1;
                        blocked_d = 1'b0;
                        drop_evt  = emit;
                    end else if (emit) begin
                        if (blocked_q || level_full) begin
                            blocked_d = 1'b1;
                            drop_evt  = 1'b1;
                        end else begin
                            push      = 1'b1;
                            push_word = trace;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (!drained_q) begin
                    if (!level_full) begin
                        push      = 1'b1;
                        push_word = trace;
                        push_last = 1'b1;
                        drained_d = 1'b1;
                        blocked_d = 1'b0;
                    end
                end else if (level_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (drop_evt && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_comb begin
        level_d  = level_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        hpri_d   = hpri_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (pop) beat_d = tlast ? 8'd1 : beat_q + 8'd1;

        if ((state_q == S_IDLE) || (level_q < cfg_l_thresh)) begin
            hpri_d = 1'b0;
        end else if (level_q >= cfg_h_thresh) begin
            hpri_d = 1'b1;
        end
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q   <= S_IDLE;
            rc_q      <= RC_WIDTH'(1);
            r_val_q   <= '0;
            blocked_q <= 1'b0;
            drained_q <= 1'b0;
            drop_q    <= '0;
            beat_q    <= 8'd1;
            hpri_q    <= 1'b0;
            level_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            rc_q      <= rc_d;
            r_val_q   <= r_val_d;
            blocked_q <= blocked_d;
            drained_q <= drained_d;
            drop_q    <= drop_d;
            beat_q    <= beat_d;
            hpri_q    <= hpri_d;
            level_q   <= level_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an empty FIFO masks whatever the array holds.
    always_ff @(posedge axis_clk) begin
        if (push) mem[wr_ptr_q] <= {push_last, push_word};
    end

    assign m_axis.m_tvalid = tvalid;
    assign m_axis.m_tdata  = tvalid ? head[TW-1:0] : '0;
    assign m_axis.m_tlast  = tlast;
    assign la_hpri_req     = hpri_q;
    assign fifo_level      = level_q;
    assign drop_count      = drop_q;
    assign la_state        = state_q;
endmodule

// File: tb/tb_la_rle_capture.sv
// Directed bench for la_rle_capture: trigger, RLE encoding, saturation, overflow/null-word, packetising, reset.
`timescale 1ns/1ps
module tb_la_rle_capture;
    localparam int NUM_CH = 24;
    localparam int TW     = 32;
    localparam int LW     = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              cfg_enable;
    logic [NUM_CH-1:0] cfg_ch_mask, cfg_trig_mask, cfg_trig_value, data;
    logic              cfg_trig_mode;
    logic [LW-1:0]     cfg_h_thresh, cfg_l_thresh;
    logic [7:0]        cfg_pkt_len;
    logic              hpri;
    logic [LW-1:0]     level;
    logic [15:0]       drops;
    logic [1:0]        st;

    int checks = 0;
    int errors = 0;
    logic [TW:0] words[$];

    la_rle_capture_if #(.TW(TW)) bus ();

    la_rle_capture dut (
        .axis_clk      (clk),
        .axis_rst      (rst),
        .cfg_enable    (cfg_enable),
        .cfg_ch_mask   (cfg_ch_mask),
        .cfg_trig_mode (cfg_trig_mode),
        .cfg_trig_mask (cfg_trig_mask),
        .cfg_trig_value(cfg_trig_value),
        .cfg_h_thresh  (cfg_h_thresh),
        .cfg_l_thresh  (cfg_l_thresh),
        .cfg_pkt_len   (cfg_pkt_len),
        .up_la_data    (data),
        .m_axis        (bus),
        .la_hpri_req   (hpri),
        .fifo_level    (level),
        .drop_count    (drops),
        .la_state      (st)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Record popped beats, then advance one clock; outputs are stable 1ns after the edge.
    task automatic step();
        if (bus.m_tvalid && bus.m_tready) words.push_back({bus.m_tlast, bus.m_tdata});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cfg_enable = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        words.delete();
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 50 && st != 2'd0; i++) step();
        check(tag, st, 2'd0);
    endtask

    initial begin
        int sum;
        logic [7:0] lastbits;
        rst = 1'b1;
        cfg_enable = 1'b0;
        cfg_ch_mask = 24'hFFFFFF;
        cfg_trig_mode = 1'b0;
        cfg_trig_mask = '0;
        cfg_trig_value = '0;
        cfg_h_thresh = 7'd48;
        cfg_l_thresh = 7'd2;
        cfg_pkt_len = 8'd200;
        data = '0;
        bus.m_tready = 1'b0;
        step();
        step();
        check("rst_tvalid", bus.m_tvalid, 1'b0);
        check("rst_tdata", bus.m_tdata, 32'h0);
        check("rst_tlast", bus.m_tlast, 1'b0);
        check("rst_level", level, 7'd0);
        check("rst_state", st, 2'd0);
        check("rst_hpri", hpri, 1'b0);
        check("rst_drops", drops, 16'd0);
        rst = 1'b0;

        // T1: immediate trigger, first run of five zeros
        cfg_enable = 1'b1;
        step();
        check("t1_armed", st, 2'd1);
        step();
        check("t1_capture", st, 2'd2);
        for (int i = 0; i < 4; i++) step();
        check("t1_no_trace_yet", bus.m_tvalid, 1'b0);
        data = 24'h000001;
        step();
        check("t1_tvalid", bus.m_tvalid, 1'b1);
        check("t1_first_word", bus.m_tdata, 32'h05000000);
        check("t1_level1", level, 7'd1);
        step();
        step();
        data = 24'h000000;
        bus.m_tready = 1'b1;
        step();
        check("t1_pushpop_level", level, 7'd1);
        check("t1_second_word", bus.m_tdata, 32'h03000001);
        bus.m_tready = 1'b0;
        cfg_enable = 1'b0;
        step();
        check("t1_drain", st, 2'd3);
        step();
        check("t1_drain_level", level, 7'd2);
        check("t1_not_last", bus.m_tlast, 1'b0);
        bus.m_tready = 1'b1;
        step();
        check("t1_final_word", bus.m_tdata, 32'h01000000);
        check("t1_final_last", bus.m_tlast, 1'b1);
        wait_idle("t1_idle");
        check("t1_empty", bus.m_tvalid, 1'b0);

        // T2: static data, counter saturation and final remainder
        do_reset();
        cfg_pkt_len = 8'd255;
        bus.m_tready = 1'b1;
        data = 24'h5A5A5A;
        cfg_enable = 1'b1;
        step();
        for (int i = 0; i < 600; i++) step();
        cfg_enable = 1'b0;
        step();
        wait_idle("t2_idle");
        check("t2_nwords", words.size(), 3);
        if (words.size() == 3) begin
            check("t2_word0", words[0], 33'h0_FF5A5A5A);
            check("t2_word1", words[1], 33'h0_FF5A5A5A);
            check("t2_word2", words[2], 33'h1_5A5A5A5A);
            sum = int'(words[0][31:24]) + int'(words[1][31:24]) + int'(words[2][31:24]);
            check("t2_sum", sum, 600);
        end

        // T3: pattern trigger on low nibble
        do_reset();
        cfg_trig_mode = 1'b1;
        cfg_trig_mask = 24'h00000F;
        cfg_trig_value = 24'h000005;
        bus.m_tready = 1'b0;
        data = 24'h000003;
        cfg_enable = 1'b1;
        step();
        step();
        step();
        check("t3_still_armed", st, 2'd1);
        data = 24'h000015;
        step();
        check("t3_triggered", st, 2'd2);
        data = 24'h000016;
        step();
        check("t3_first_trace", bus.m_tdata, 32'h01000015);
        cfg_trig_mode = 1'b0;

        // T4: overflow, drop counting, null-word resync
        do_reset();
        bus.m_tready = 1'b0;
        data = '0;
        cfg_enable = 1'b1;
        step();
        step();
        for (int i = 0; i < 70; i++) begin
            data = data ^ 24'h1;
            step();
        end
        check("t4_full", level, 7'd64);
        check("t4_drops", drops, 16'd6);
        check("t4_hpri", hpri, 1'b1);
        bus.m_tready = 1'b1;
        for (int i = 0; i < 70; i++) begin
            data = data ^ 24'h1;
            step();
        end
        check("t4_drops_after", drops, 16'd69);
        check("t4_level_after", level, 7'd2);
        check("t4_npops", words.size(), 70);
        if (words.size() == 70) begin
            check("t4_word0", words[0], 33'h0_01000000);
            check("t4_word63", words[63][31:24], 8'h01);
            check("t4_null", words[64], 33'h0);
            check("t4_resume", words[65], 33'h0_01000001);
        end

        // T5: packets of three, final drain beat closes the stream
        do_reset();
        cfg_pkt_len = 8'd3;
        bus.m_tready = 1'b1;
        data = '0;
        cfg_enable = 1'b1;
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            data = data ^ 24'h1;
            step();
        end
        cfg_enable = 1'b0;
        step();
        wait_idle("t5_idle");
        check("t5_nwords", words.size(), 8);
        if (words.size() == 8) begin
            lastbits = '0;
            for (int i = 0; i < 8; i++) lastbits[i] = words[i][TW];
            check("t5_tlast_pattern", lastbits, 8'b1010_0100);
            check("t5_final_word", words[7][31:0], 32'h01000001);
        end

        // T6: asynchronous reset with queued traces
        do_reset();
        cfg_pkt_len = 8'd255;
        cfg_h_thresh = 7'd4;
        bus.m_tready = 1'b0;
        data = '0;
        cfg_enable = 1'b1;
        step();
        step();
        for (int i = 0; i < 10; i++) begin
            data = data ^ 24'h1;
            step();
        end
        check("t6_level10", level, 7'd10);
        check("t6_hpri_set", hpri, 1'b1);
        cfg_enable = 1'b0;
        rst = 1'b1;
        #1;
        check("t6_tvalid", bus.m_tvalid, 1'b0);
        check("t6_level", level, 7'd0);
        check("t6_state", st, 2'd0);
        check("t6_hpri", hpri, 1'b0);
        step();
        check("t6_tvalid_edge", bus.m_tvalid, 1'b0);
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
